// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit: 2-cycle latency, 1 op/cycle when output ready is held high.
// Output stalls hold the result and flags; the input stage fills and then drops LOGIC_IN_READY.
module logic_unit_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int B_WIDTH    = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK_LOGIC,
    input  logic                  RST_LOGIC,
    input  logic [DATA_WIDTH-1:0] A_IN_LOGIC,
    input  logic [B_WIDTH-1:0]    B_IN_LOGIC,
    input  logic [2:0]            ALU_FUN_LOGIC,
    input  logic                  LOGIC_EN,
    output logic                  LOGIC_IN_READY,
    output logic [DATA_WIDTH-1:0] LOGIC_OUT,
    output logic                  LOGIC_FLAG,
    input  logic                  LOGIC_OUT_READY,
    output logic                  LOGIC_ZERO,
    output logic                  LOGIC_PARITY,
    output logic [CNT_WIDTH-1:0]  LOGIC_OP_CNT
);

    function automatic logic [DATA_WIDTH-1:0] logic_fn(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [2:0]            fun
    );
        logic [DATA_WIDTH-1:0] r;
        case (fun)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = ~(a & b);
            3'b011:  r = ~(a | b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a & ~b;
            default: r = ~a;
        endcase
        return r;
    endfunction

    logic                  s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]            s1_fun_q, s1_fun_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [DATA_WIDTH-1:0] s2_dat_q, s2_dat_d;
    logic                  s2_zero_q, s2_zero_d;
    logic                  s2_par_q, s2_par_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  s2_free;
    logic                  s1_adv;
    logic                  in_rdy;
    logic                  accept;
    logic                  handoff;
    logic [DATA_WIDTH-1:0] b_ext;
    logic [DATA_WIDTH-1:0] s1_res;

    always_comb begin
        s2_free = !s2_vld_q || LOGIC_OUT_READY;
        s1_adv  = s1_vld_q && s2_free;
        in_rdy  = !s1_vld_q || s2_free;
        accept  = LOGIC_EN && in_rdy;
        handoff = s2_vld_q && LOGIC_OUT_READY;
        b_ext   = DATA_WIDTH'(B_IN_LOGIC);
        s1_res  = logic_fn(s1_a_q, s1_b_q, s1_fun_q);
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_fun_d  = s1_fun_q;
        s2_vld_d  = s2_vld_q;
        s2_dat_d  = s2_dat_q;
        s2_zero_d = s2_zero_q;
        s2_par_d  = s2_par_q;
        cnt_d     = cnt_q + CNT_WIDTH'(handoff);

        // An accept refills s1 even when its previous occupant advances on the same edge.
        if (accept) begin
            s1_vld_d = 1'b1;
            s1_a_d   = A_IN_LOGIC;
            s1_b_d   = b_ext;
            s1_fun_d = ALU_FUN_LOGIC;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        if (s1_adv) begin
            s2_vld_d  = 1'b1;
            s2_dat_d  = s1_res;
            s2_zero_d = (s1_res == '0);
            s2_par_d  = ^s1_res;
        end else if (handoff) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_LOGIC) begin
        if (RST_LOGIC) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_fun_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s2_zero_q <= 1'b0;
            s2_par_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_fun_q  <= s1_fun_d;
            s2_vld_q  <= s2_vld_d;
            s2_dat_q  <= s2_dat_d;
            s2_zero_q <= s2_zero_d;
            s2_par_q  <= s2_par_d;
            cnt_q     <= cnt_d;
        end
    end

    assign LOGIC_IN_READY = in_rdy;
    assign LOGIC_FLAG     = s2_vld_q;
    assign LOGIC_OUT      = s2_dat_q;
    assign LOGIC_ZERO     = s2_zero_q;
    assign LOGIC_PARITY   = s2_par_q;
    assign LOGIC_OP_CNT   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: a 16-bit-B instance and an 8-bit-B / 4-bit-counter instance share stimulus.
// A queue-based reference model tracks in-flight ops, result order, readiness and the completion count.
module tb_logic_unit_pipe;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  fun;
        logic [1:0]  kmask;
        logic        kflags;
        logic [15:0] k0;
        logic [15:0] k1;
        logic        kz;
        logic        kp;
    } op_t;

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        int          acc;
        op_t         op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic [2:0]  fun_in = '0;
    logic        en = 1'b0;
    logic        out_rdy = 1'b1;

    logic        rdy0, flag0, zero0, par0;
    logic [15:0] out0;
    logic [7:0]  cnt0;
    logic        rdy1, flag1, zero1, par1;
    logic [15:0] out1;
    logic [3:0]  cnt1;

    int n_cmp = 0;
    int n_err = 0;

    op_t  ops[$];
    exp_t q[$];
    int   rd = 0;
    int   cyc = 0;
    int   cnt_m = 0;
    int   n_acc = 0;
    logic armed = 1'b0;
    logic just_rst = 1'b0;
    logic rst_req = 1'b1;
    int   mode = 1;
    logic gaps = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.DATA_WIDTH(16), .B_WIDTH(16), .CNT_WIDTH(8)) u_dut0 (
        .CLK_LOGIC(clk), .RST_LOGIC(rst), .A_IN_LOGIC(a_in), .B_IN_LOGIC(b_in),
        .ALU_FUN_LOGIC(fun_in), .LOGIC_EN(en), .LOGIC_IN_READY(rdy0), .LOGIC_OUT(out0),
        .LOGIC_FLAG(flag0), .LOGIC_OUT_READY(out_rdy), .LOGIC_ZERO(zero0),
        .LOGIC_PARITY(par0), .LOGIC_OP_CNT(cnt0)
    );

    logic_unit_pipe #(.DATA_WIDTH(16), .B_WIDTH(8), .CNT_WIDTH(4)) u_dut1 (
        .CLK_LOGIC(clk), .RST_LOGIC(rst), .A_IN_LOGIC(a_in), .B_IN_LOGIC(b_in[7:0]),
        .ALU_FUN_LOGIC(fun_in), .LOGIC_EN(en), .LOGIC_IN_READY(rdy1), .LOGIC_OUT(out1),
        .LOGIC_FLAG(flag1), .LOGIC_OUT_READY(out_rdy), .LOGIC_ZERO(zero1),
        .LOGIC_PARITY(par1), .LOGIC_OP_CNT(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_fn(input logic [15:0] a, input logic [15:0] bz,
                                           input logic [2:0] fun);
        case (fun)
            3'd0:    return a & bz;
            3'd1:    return a | bz;
            3'd2:    return ~(a & bz);
            3'd3:    return ~(a | bz);
            3'd4:    return a ^ bz;
            3'd5:    return ~(a ^ bz);
            3'd6:    return a & ~bz;
            default: return ~a;
        endcase
    endfunction

    function automatic op_t mk_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] fun);
        op_t o;
        o.a = a; o.b = b; o.fun = fun;
        o.kmask = 2'b00; o.kflags = 1'b0;
        o.k0 = '0; o.k1 = '0; o.kz = 1'b0; o.kp = 1'b0;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk_op(16'($urandom), 16'($urandom), 3'($urandom));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: offers the next unaccepted op, otherwise idles with garbage on the data inputs.
    always @(posedge clk) begin
        #1;
        rst <= rst_req;
        case (mode)
            0:       out_rdy <= 1'b0;
            1:       out_rdy <= 1'b1;
            default: out_rdy <= ($urandom_range(0, 2) != 0);
        endcase
        if (rd < ops.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
            en     <= 1'b1;
            a_in   <= ops[rd].a;
            b_in   <= ops[rd].b;
            fun_in <= ops[rd].fun;
        end else begin
            en     <= 1'b0;
            a_in   <= 16'($urandom);
            b_in   <= 16'($urandom);
            fun_in <= 3'($urandom);
        end
    end

    // Reference model: at most two ops in flight; the oldest becomes visible two edges after its accept.
    always @(negedge clk) begin
        logic        exp_flag;
        logic        exp_rdy;
        logic [15:0] bz1;
        exp_t        e;
        exp_flag = (q.size() > 0) && (cyc - q[0].acc >= 2);
        exp_rdy  = (q.size() < 2) || out_rdy;
        if (armed) begin
            check("in_ready0", rdy0, exp_rdy);
            check("in_ready1", rdy1, exp_rdy);
            check("flag0", flag0, exp_flag);
            check("flag1", flag1, exp_flag);
            check("op_cnt0", cnt0, cnt_m % 256);
            check("op_cnt1", cnt1, cnt_m % 16);
            if (just_rst) begin
                check("rst_out0", out0, 0);
                check("rst_out1", out1, 0);
                check("rst_zero0", zero0, 0);
                check("rst_par0", par0, 0);
            end
            if (exp_flag) begin
                check("out0", out0, q[0].e0);
                check("out1", out1, q[0].e1);
                check("zero0", zero0, q[0].e0 == 16'h0);
                check("zero1", zero1, q[0].e1 == 16'h0);
                check("parity0", par0, ^q[0].e0);
                check("parity1", par1, ^q[0].e1);
            end
        end
        if (rst) begin
            q.delete();
            rd       = ops.size();
            cnt_m    = 0;
            just_rst = 1'b1;
            armed    = 1'b1;
        end else begin
            just_rst = 1'b0;
            if (exp_flag && out_rdy) begin
                if (q[0].op.kmask[0]) check("spec_out0", out0, q[0].op.k0);
                if (q[0].op.kmask[1]) check("spec_out1", out1, q[0].op.k1);
                if (q[0].op.kflags) begin
                    check("spec_zero0", zero0, q[0].op.kz);
                    check("spec_parity0", par0, q[0].op.kp);
                end
                void'(q.pop_front());
                cnt_m++;
            end
            if (en && exp_rdy && rd < ops.size()) begin
                bz1   = {8'h00, ops[rd].b[7:0]};
                e.e0  = ref_fn(ops[rd].a, ops[rd].b, ops[rd].fun);
                e.e1  = ref_fn(ops[rd].a, bz1, ops[rd].fun);
                e.acc = cyc;
                e.op  = ops[rd];
                q.push_back(e);
                rd++;
                n_acc++;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((rd < ops.size() || q.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] stream_k [8];
        logic [15:0] hold;
        op_t         o;
        int          base;

        stream_k = '{16'h00F0, 16'hFFF0, 16'hFF0F, 16'h000F,
                     16'hFF00, 16'h00FF, 16'hF000, 16'h0F0F};
        repeat (3) @(posedge clk);
        rst_req = 1'b0;

        mode = 1;
        for (int i = 0; i < 8; i++) begin
            o = mk_op(16'hF0F0, 16'h0FF0, 3'(i));
            o.kmask = 2'b01;
            o.k0 = stream_k[i];
            ops.push_back(o);
        end
        wait_drain(200);
        check("stream_cnt", cnt0, 8);

        o = mk_op(16'h1234, 16'h1234, 3'b100);
        o.kmask = 2'b01; o.kflags = 1'b1; o.k0 = 16'h0000; o.kz = 1'b1; o.kp = 1'b0;
        ops.push_back(o);
        o = mk_op(16'h0007, 16'hFFFF, 3'b000);
        o.kmask = 2'b01; o.kflags = 1'b1; o.k0 = 16'h0007; o.kz = 1'b0; o.kp = 1'b1;
        ops.push_back(o);
        o = mk_op(16'hABCD, 16'h00FF, 3'b001);
        o.kmask = 2'b11; o.k0 = 16'hABFF; o.k1 = 16'hABFF;
        ops.push_back(o);
        o = mk_op(16'hABCD, 16'h00FF, 3'b110);
        o.kmask = 2'b11; o.k0 = 16'hAB00; o.k1 = 16'hAB00;
        ops.push_back(o);
        wait_drain(200);

        mode = 0;
        base = n_acc;
        for (int i = 0; i < 4; i++) ops.push_back(rand_op());
        repeat (8) @(negedge clk);
        check("bp_accepted", n_acc - base, 2);
        check("bp_in_ready", rdy0, 0);
        hold = out0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", out0, hold);
        end
        mode = 1;
        wait_drain(200);
        check("bp_all_accepted", n_acc - base, 4);

        pulse_reset();
        for (int i = 0; i < 17; i++) ops.push_back(rand_op());
        wait_drain(500);
        check("wrap_cnt1", cnt1, 1);
        check("wrap_cnt0", cnt0, 17);

        mode = 0;
        ops.push_back(rand_op());
        ops.push_back(rand_op());
        repeat (5) @(negedge clk);
        check("mid_flag_before", flag0, 1);
        pulse_reset();
        check("mid_flag", flag0, 0);
        check("mid_out", out0, 0);
        check("mid_cnt", cnt0, 0);
        check("mid_in_ready", rdy0, 1);
        mode = 1;
        repeat (6) @(negedge clk);
        check("mid_no_stale", flag0, 0);

        mode = 2;
        gaps = 1'b1;
        for (int i = 0; i < 400; i++) ops.push_back(rand_op());
        wait_drain(8000);
        check("random_all_accepted", rd, ops.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
